// File: rtl/uart_tx_scheduler_if.sv
// Client request/ack bundle plus TX FIFO write/status lines for uart_tx_scheduler.
// master: the clients and FIFO environment. slave: the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]   REQ;
  logic [8*NUM_CLIENTS-1:0] CLIENT_DATA;
  logic [NUM_CLIENTS-1:0]   CLIENT_LAST;
  logic [NUM_CLIENTS-1:0]   CLIENT_ACK;
  logic [NUM_CLIENTS-1:0]   GRANT;
  logic                     ABORT;
  logic [31:0]              TX_WD;
  logic                     TX_WE;
  logic [31:0]              TX_RD;
  logic                     BUSY;

  modport master (
    output REQ, CLIENT_DATA, CLIENT_LAST, TX_RD,
    input  CLIENT_ACK, GRANT, ABORT, TX_WD, TX_WE, BUSY
  );

  modport slave (
    input  REQ, CLIENT_DATA, CLIENT_LAST, TX_RD,
    output CLIENT_ACK, GRANT, ABORT, TX_WD, TX_WE, BUSY
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that moves client byte streams into a UART TX FIFO.
// A packet owner keeps its grant until LAST or an idle timeout; bursts are
// capped at MAX_BURST bytes per empty-FIFO window so the FIFO never overflows.
module uart_tx_scheduler #(
  parameter int NUM_CLIENTS  = 4,
  parameter int MAX_BURST    = 31,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  uart_tx_scheduler_if.slave    bus
);
  localparam int IW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int IDW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARB        = 3'd1,
    WAIT_EMPTY = 3'd2,
    XFER       = 3'd3,
    SETTLE     = 3'd4
  } state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          gidx;
  logic [NUM_CLIENTS-1:0] grant;
  logic [BW-1:0]          burst_cnt;
  logic [IDW-1:0]         idle_cnt;
  logic                   abort_q;

  logic                   timeout;
  logic                   req_g;
  logic                   last_g;
  logic                   wr;
  logic [7:0]             data_g;
  logic [IW-1:0]          gnext;
  logic                   arb_hit;
  logic [IW-1:0]          arb_idx;
  logic                   unused_rd;

  // Only the empty/idle flag of the FIFO status matters here.
  assign unused_rd = ^bus.TX_RD[31:1];

  assign timeout = (state == XFER) && (idle_cnt == IDW'(IDLE_TIMEOUT));
  assign req_g   = bus.REQ[gidx];
  assign last_g  = bus.CLIENT_LAST[gidx];
  // Zero-latency pass-through; reset and the abort cycle suppress the write.
  assign wr      = (state == XFER) && req_g && !timeout && !RESET;
  assign gnext   = (gidx == IW'(NUM_CLIENTS - 1)) ? '0 : gidx + 1'b1;

  assign bus.TX_WE      = wr;
  assign bus.CLIENT_ACK = wr ? grant : '0;
  assign bus.TX_WD      = {24'd0, data_g};
  assign bus.GRANT      = grant;
  assign bus.ABORT      = abort_q;
  assign bus.BUSY       = (state != IDLE);

  // Byte mux for the granted client.
  always_comb begin
    data_g = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (gidx == IW'(i)) data_g = bus.CLIENT_DATA[8*i +: 8];
  end

  // First requester at or after rr_ptr; scanning downward lets the nearest win.
  always_comb begin
    int idx;
    logic [IW-1:0] ci;
    idx     = 0;
    ci      = '0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
      ci  = IW'(idx);
      if (bus.REQ[ci]) begin
        arb_hit = 1'b1;
        arb_idx = ci;
      end
    end
  end

  // Scheduler FSM with registered grant/abort and packet bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: if (|bus.REQ) state <= ARB;
        ARB: begin
          if (arb_hit) begin
            grant <= NUM_CLIENTS'(1) << arb_idx;
            gidx  <= arb_idx;
            state <= WAIT_EMPTY;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_EMPTY: begin
          idle_cnt <= '0;
          if (bus.TX_RD[0]) begin
            burst_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (timeout) begin
            abort_q  <= 1'b1;
            grant    <= '0;
            rr_ptr   <= gnext;
            idle_cnt <= '0;
            state    <= SETTLE;
          end else if (wr) begin
            idle_cnt <= '0;
            if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
            if (last_g) begin
              grant  <= '0;
              rr_ptr <= gnext;
              state  <= SETTLE;
            end else if (burst_cnt == BW'(MAX_BURST - 1)) begin
              state <= SETTLE;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        // One cycle for the FIFO empty flag to catch up with our writes.
        SETTLE: state <= (|grant) ? WAIT_EMPTY : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, single packet, round robin,
// burst split, idle timeout, reset mid-transfer and FIFO-not-empty stall.
module tb_uart_tx_scheduler;
  logic CLK = 1'b0;
  logic RESET;
  int checks = 0;
  int failures = 0;

  uart_tx_scheduler_if #(.NUM_CLIENTS(4)) bus ();

  uart_tx_scheduler #(.NUM_CLIENTS(4), .MAX_BURST(31), .IDLE_TIMEOUT(255)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic set_data(input int c, input logic [7:0] v);
    bus.CLIENT_DATA[8*c +: 8] = v;
  endtask

  // Wait (bounded) for a write; expiry shows up as a failed TX_WE check.
  task automatic wait_we(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      sample();
      if (bus.TX_WE) break;
      adv();
    end
    check({tag, "_we"}, bus.TX_WE, 1'b1);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    adv();
    RESET = 1'b0;
  endtask

  initial begin
    bit ok;
    RESET           = 1'b1;
    bus.REQ         = '0;
    bus.CLIENT_DATA = '0;
    bus.CLIENT_LAST = '0;
    bus.TX_RD       = 32'd1;

    // Reset state
    adv(); adv();
    sample();
    check("rst_grant", bus.GRANT, 4'b0000);
    check("rst_busy",  bus.BUSY, 1'b0);
    check("rst_we",    bus.TX_WE, 1'b0);
    check("rst_ack",   bus.CLIENT_ACK, 4'b0000);
    check("rst_abort", bus.ABORT, 1'b0);
    check("rst_rrptr", dut.rr_ptr, 2'd0);
    adv();
    RESET = 1'b0;

    // Single packet from client 2: 0x41, 0x42, 0x43(LAST)
    bus.REQ = 4'b0100; set_data(2, 8'h41); bus.TX_RD = 32'd1;
    adv(); adv();
    sample();
    check("sp_grant", bus.GRANT, 4'b0100);
    check("sp_wait_state", dut.state, 3'd2);
    adv(); sample();
    check("sp_we0", bus.TX_WE, 1'b1);
    check("sp_wd0", bus.TX_WD, 32'h41);
    check("sp_ack0", bus.CLIENT_ACK, 4'b0100);
    adv(); set_data(2, 8'h42); sample();
    check("sp_wd1", bus.TX_WD, 32'h42);
    check("sp_we1", bus.TX_WE, 1'b1);
    adv(); set_data(2, 8'h43); bus.CLIENT_LAST = 4'b0100; sample();
    check("sp_wd2", bus.TX_WD, 32'h43);
    check("sp_we2", bus.TX_WE, 1'b1);
    adv(); bus.REQ = '0; bus.CLIENT_LAST = '0; sample();
    check("sp_settle", dut.state, 3'd4);
    check("sp_grant_clr", bus.GRANT, 4'b0000);
    check("sp_we_off", bus.TX_WE, 1'b0);
    adv(); sample();
    check("sp_idle", dut.state, 3'd0);
    check("sp_rrptr", dut.rr_ptr, 2'd3);
    check("sp_busy", bus.BUSY, 1'b0);
    adv();

    // Round robin with all clients requesting 1-byte packets
    pulse_reset();
    bus.REQ = 4'b1111; bus.CLIENT_LAST = 4'b1111;
    bus.CLIENT_DATA = 32'hD3D2D1D0;
    for (int n = 0; n < 5; n++) begin
      wait_we("rr", 12);
      check("rr_ack",   bus.CLIENT_ACK, 4'b0001 << (n % 4));
      check("rr_grant", bus.GRANT, 4'b0001 << (n % 4));
      check("rr_wd",    bus.TX_WD, 32'hD0 + (n % 4));
      adv();
    end
    bus.REQ = '0; bus.CLIENT_LAST = '0;

    // Burst split: 40-byte packet from client 1, client 0 competing
    pulse_reset();
    bus.REQ = 4'b0010; bus.TX_RD = 32'd1; set_data(1, 8'd0); set_data(0, 8'hEE);
    adv(); adv();
    bus.REQ = 4'b0011;
    sample();
    check("bs_grant", bus.GRANT, 4'b0010);
    ok = 1'b1;
    for (int n = 0; n < 31; n++) begin
      adv(); set_data(1, 8'(n)); sample();
      if (!(bus.TX_WE === 1'b1 && bus.TX_WD === 32'(n) && bus.CLIENT_ACK === 4'b0010)) ok = 1'b0;
    end
    check("bs_first31", ok, 1'b1);
    adv(); bus.TX_RD = 32'd0; set_data(1, 8'd31); sample();
    check("bs_settle", dut.state, 3'd4);
    check("bs_settle_we", bus.TX_WE, 1'b0);
    check("bs_settle_grant", bus.GRANT, 4'b0010);
    adv(); sample();
    check("bs_wait", dut.state, 3'd2);
    check("bs_wait_ack", bus.CLIENT_ACK, 4'b0000);
    adv(); sample();
    check("bs_wait_we", bus.TX_WE, 1'b0);
    bus.TX_RD = 32'd1;
    ok = 1'b1;
    for (int n = 31; n < 40; n++) begin
      adv(); set_data(1, 8'(n)); bus.CLIENT_LAST = (n == 39) ? 4'b0010 : 4'b0000; sample();
      if (!(bus.TX_WE === 1'b1 && bus.TX_WD === 32'(n) && bus.CLIENT_ACK === 4'b0010)) ok = 1'b0;
    end
    check("bs_last9", ok, 1'b1);
    adv(); bus.CLIENT_LAST = 4'b0001; sample();
    check("bs_end_grant", bus.GRANT, 4'b0000);
    check("bs_rrptr", dut.rr_ptr, 2'd2);
    adv();
    wait_we("bs_c0", 12);
    check("bs_c0_ack", bus.CLIENT_ACK, 4'b0001);
    check("bs_c0_wd", bus.TX_WD, 32'hEE);
    adv(); bus.REQ = '0; bus.CLIENT_LAST = '0;

    // Idle timeout: client 0 stalls after 2 bytes, client 1 waiting
    pulse_reset();
    bus.REQ = 4'b0001; set_data(0, 8'h10); bus.TX_RD = 32'd1;
    wait_we("to", 12);
    check("to_wd0", bus.TX_WD, 32'h10);
    adv(); set_data(0, 8'h11); sample();
    check("to_wd1", bus.TX_WD, 32'h11);
    adv(); bus.REQ = 4'b0010; bus.CLIENT_LAST = 4'b0010; set_data(1, 8'h77);
    ok = 1'b1;
    for (int k = 0; k < 255; k++) begin
      sample();
      if (!(bus.TX_WE === 1'b0 && bus.ABORT === 1'b0 && bus.GRANT === 4'b0001 &&
            bus.CLIENT_ACK === 4'b0000)) ok = 1'b0;
      adv();
    end
    check("to_bubbles", ok, 1'b1);
    sample();
    check("to_abort_cyc_we", bus.TX_WE, 1'b0);
    check("to_abort_cyc_abort", bus.ABORT, 1'b0);
    adv(); sample();
    check("to_abort", bus.ABORT, 1'b1);
    check("to_grant", bus.GRANT, 4'b0000);
    check("to_rrptr", dut.rr_ptr, 2'd1);
    adv(); sample();
    check("to_abort_off", bus.ABORT, 1'b0);
    adv();
    wait_we("to_c1", 12);
    check("to_c1_ack", bus.CLIENT_ACK, 4'b0010);
    check("to_c1_wd", bus.TX_WD, 32'h77);
    adv(); bus.REQ = '0; bus.CLIENT_LAST = '0;

    // Reset after the 5th byte of a 10-byte packet from client 2
    bus.REQ = 4'b0100; set_data(2, 8'd0);
    wait_we("rm", 12);
    check("rm_wd0", bus.TX_WD, 32'd0);
    for (int n = 1; n < 5; n++) begin
      adv(); set_data(2, 8'(n)); sample();
      check("rm_wd", bus.TX_WD, 32'(n));
    end
    adv(); RESET = 1'b1; set_data(2, 8'd5); sample();
    check("rm_rst_cyc_we", bus.TX_WE, 1'b0);
    adv(); RESET = 1'b0; bus.REQ = '0; sample();
    check("rm_we", bus.TX_WE, 1'b0);
    check("rm_grant", bus.GRANT, 4'b0000);
    check("rm_busy", bus.BUSY, 1'b0);
    check("rm_rrptr", dut.rr_ptr, 2'd0);
    adv();

    // FIFO not empty for 100 cycles; upper status bits set to show they are ignored
    bus.REQ = 4'b1000; bus.CLIENT_LAST = 4'b1000; set_data(3, 8'h5A);
    bus.TX_RD = 32'hFFFF_FFFE;
    adv(); adv();
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      sample();
      if (!(bus.TX_WE === 1'b0 && bus.GRANT === 4'b1000)) ok = 1'b0;
      adv();
    end
    check("fe_stall", ok, 1'b1);
    bus.TX_RD = 32'd1; sample();
    check("fe_rise_we", bus.TX_WE, 1'b0);
    adv(); sample();
    check("fe_we", bus.TX_WE, 1'b1);
    check("fe_wd", bus.TX_WD, 32'h5A);
    check("fe_ack", bus.CLIENT_ACK, 4'b1000);
    adv(); bus.REQ = '0; bus.CLIENT_LAST = '0;
    adv(); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of requesting clients, range 2..8.
REQ-002 SHALL have parameter MAX_BURST, default 31: maximum bytes written per empty-FIFO window; must be less than the TX FIFO depth (32).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 255: number of bubble cycles mid-packet before the grant is revoked.
REQ-004 Clocking and reset: clock CLK; reset RESET, synchronous, active-high.
REQ-005 Client request inputs: REQ, input, NUM_CLIENTS bits; client i has a byte valid.
REQ-006 Client data inputs: CLIENT_DATA, input, 8*NUM_CLIENTS bits; byte of client i at [8i+7:8i].
REQ-007 Packet delimiter inputs: CLIENT_LAST, input, NUM_CLIENTS bits; the current byte of client i ends its packet.
REQ-008 Byte acknowledge outputs: CLIENT_ACK, output, NUM_CLIENTS bits; the byte of client i is consumed this cycle.
REQ-009 Grant outputs: GRANT, output, NUM_CLIENTS bits; one-hot owner, or zero.
REQ-010 ABORT, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.
REQ-011 TX FIFO write data: TX_WD, output, 32 bits; {24'd0, byte}.
REQ-012 TX FIFO write enable: TX_WE, output, 1 bit.
REQ-013 TX FIFO status: TX_RD, input, 32 bits; bit 0 is FIFO empty and the transmitter idle.
REQ-014 BUSY, output, 1 bit: the state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, ARB, WAIT_EMPTY, XFER and SETTLE.
REQ-016 IDLE: if any REQ bit is high, the next state SHALL be ARB.
REQ-017 ARB: SHALL select the first requesting client at or after rr_ptr, wrapping modulo NUM_CLIENTS, and register it in GRANT.
- Next state is WAIT_EMPTY.
- If no REQ bit is high in ARB, the next state is IDLE.
REQ-018 WAIT_EMPTY: when TX_RD[0]=1, SHALL clear burst_cnt and go to XFER.
REQ-019 XFER: TX_WE, the granted CLIENT_ACK bit and TX_WD SHALL be combinational.
- TX_WE = CLIENT_ACK[g] = REQ[g].
- TX_WD = {24'd0, CLIENT_DATA of g}.
- There is zero latency from REQ to ACK.
REQ-020 Each write SHALL increment burst_cnt.
REQ-021 A write with CLIENT_LAST[g]=1 SHALL end the packet.
- GRANT is cleared.
- rr_ptr becomes g+1 modulo NUM_CLIENTS.
- Next state is SETTLE.
REQ-022 If a write makes burst_cnt equal MAX_BURST without LAST, the grant SHALL be kept and the next state SHALL be SETTLE.
REQ-023 SETTLE: SHALL last exactly one cycle, which covers the one-cycle lag of the FIFO pointer updating TX_RD[0].
- If GRANT is nonzero, the next state is WAIT_EMPTY.
- Otherwise, the next state is IDLE.
REQ-024 Within a packet, a client keeps its grant; no other client SHALL receive ACK until LAST or ABORT.
REQ-025 A non-granted client SHALL never receive ACK, and TX_WE SHALL be 0 outside XFER.
REQ-026 Bubble in XFER: if REQ[g]=0, no write SHALL occur and idle_cnt SHALL increment.
- idle_cnt clears on any write.
REQ-027 When idle_cnt reaches IDLE_TIMEOUT, the block SHALL execute an abort.
- ABORT pulses for one cycle.
- GRANT is cleared.
- rr_ptr becomes g+1.
- Next state is SETTLE.
- No byte is written that cycle.
REQ-028 If the granted REQ deasserts in WAIT_EMPTY, the grant SHALL be kept (no timeout there).
REQ-029 TX_RD[31:1] SHALL be ignored.
REQ-030 Counters SHALL never wrap: burst_cnt saturates at MAX_BURST, and idle_cnt is wide enough to hold IDLE_TIMEOUT.

Reset
REQ-031 On RESET, the following SHALL hold on the next edge:
- state=IDLE, rr_ptr=0, GRANT=0, burst_cnt=0, idle_cnt=0.
- ABORT=0, TX_WE=0, CLIENT_ACK=0, BUSY=0.
REQ-032 RESET SHALL take priority over all other events.
- RESET mid-XFER drops the grant with no further TX_WE.
- The partially sent packet is not resumed.

Verification
REQ-033 Single packet: REQ[2]=1 with 3 bytes 0x41,0x42,0x43 (LAST on 0x43), TX_RD[0]=1.
- Response: GRANT=4'b0100; 3 consecutive TX_WE with TX_WD=0x41,0x42,0x43; then SETTLE, IDLE, rr_ptr=3.
REQ-034 Round robin: REQ=4'b1111 continuously, 1-byte packets.
- Response: grant order 0,1,2,3,0; no client is granted twice before the others.
REQ-035 Burst split: client 1 sends a 40-byte packet.
- Response: 31 writes, then SETTLE and WAIT_EMPTY until TX_RD[0]=1, then 9 writes.
- GRANT=4'b0010 throughout.
- A competing REQ[0] gets no ACK until after the final LAST.
REQ-036 Timeout: client 0 drops REQ after 2 of 5 bytes.
- Response: after 255 bubble cycles, ABORT=1 for one cycle; GRANT=0; a waiting client 1 is granted next.
REQ-037 Reset mid-transfer: RESET asserted in the cycle after the 5th write of a 10-byte packet.
- Response: the next cycle shows TX_WE=0, GRANT=0, BUSY=0, and rr_ptr=0.
REQ-038 FIFO not empty: TX_RD[0]=0 held for 100 cycles with REQ[3]=1.
- Response: GRANT=4'b1000, TX_WE=0 throughout.
- The first write occurs in the cycle after TX_RD[0] rises.
